// File: rtl/precursor_tracker_multi_if.sv
// rtl/precursor_tracker_multi_if.sv - timestep, config and result bundle for precursor_tracker_multi
// Optional read-back signals exist only when PRECURSOR_GROUP_READ_EN is defined.
interface precursor_tracker_multi_if #(
    parameter int NUM_GROUPS = 6,
    parameter int FLUX_W     = 51,
    parameter int ACC_W      = 64
);
    localparam int GW    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int SUM_W = ACC_W + $clog2(NUM_GROUPS) + 1;

    logic              new_timestep;
    logic [FLUX_W-1:0] neutron_flux;
    logic              cfg_we;
    logic [GW-1:0]     cfg_group;
    logic [1:0]        cfg_sel;
    logic [ACC_W-1:0]  cfg_data;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  precursor_neutrons;
    logic              sat;
    logic              overrun;
`ifdef PRECURSOR_GROUP_READ_EN
    logic [GW-1:0]     rd_group;
    logic [ACC_W-1:0]  rd_amount;
    logic [ACC_W-1:0]  rd_neutrons;

    modport master (
        output new_timestep, neutron_flux, cfg_we, cfg_group, cfg_sel, cfg_data, rd_group,
        input  busy, done, precursor_neutrons, sat, overrun, rd_amount, rd_neutrons
    );
    modport slave (
        input  new_timestep, neutron_flux, cfg_we, cfg_group, cfg_sel, cfg_data, rd_group,
        output busy, done, precursor_neutrons, sat, overrun, rd_amount, rd_neutrons
    );
`else
    modport master (
        output new_timestep, neutron_flux, cfg_we, cfg_group, cfg_sel, cfg_data,
        input  busy, done, precursor_neutrons, sat, overrun
    );
    modport slave (
        input  new_timestep, neutron_flux, cfg_we, cfg_group, cfg_sel, cfg_data,
        output busy, done, precursor_neutrons, sat, overrun
    );
`endif
endinterface

// File: rtl/precursor_tracker_multi.sv
// rtl/precursor_tracker_multi.sv - multi-group delayed-neutron precursor tracker with shared multipliers
// Optional per-group read-back port enabled by PRECURSOR_GROUP_READ_EN.
module precursor_tracker_multi #(
    parameter int NUM_GROUPS            = 6,
    parameter int LOG2_STEPS_PER_SECOND = 14,
    parameter int FLUX_W                = 51,
    parameter int ACC_W                 = 64,
    parameter int COEF_W                = 24
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    precursor_tracker_multi_if.slave   bus
);
    localparam int GW    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int SUM_W = ACC_W + $clog2(NUM_GROUPS) + 1;
    localparam int SRC_W = FLUX_W + COEF_W;
    localparam int PL_W  = ACC_W + COEF_W;
    localparam logic [GW:0]   GROUPS     = (GW+1)'(NUM_GROUPS);
    localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, MUL, UPD, SUM} state_t;

    state_t state, next_state;

    logic [ACC_W-1:0]  c_mem      [NUM_GROUPS];
    logic [ACC_W-1:0]  p_mem      [NUM_GROUPS];
    logic [COEF_W-1:0] beta_mem   [NUM_GROUPS];
    logic [COEF_W-1:0] lambda_mem [NUM_GROUPS];

    logic [FLUX_W-1:0] flux_q;
    logic [GW-1:0]     idx;
    logic [FLUX_W-1:0] src_q;
    logic [ACC_W-1:0]  p_new_q;
    logic [SUM_W-1:0]  acc;

    logic accept, do_mul, do_upd, do_sum, cfg_ok, last_group;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.new_timestep) next_state = MUL;
            MUL:  next_state = UPD;
            UPD:  next_state = last_group ? SUM : MUL;
            SUM:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        accept     = (state == IDLE) && bus.new_timestep;
        do_mul     = (state == MUL);
        do_upd     = (state == UPD);
        do_sum     = (state == SUM);
        last_group = (idx == LAST_GROUP);
        // Writes to nonexistent groups or the reserved selector vanish silently
        cfg_ok     = (state == IDLE) && bus.cfg_we && ({1'b0, bus.cfg_group} < GROUPS)
                     && (bus.cfg_sel != 2'd3);
    end

    // ---------------- update arithmetic ----------------
    logic [ACC_W-1:0] c_cur, p_cur, p_dec, c_new;
    logic [ACC_W:0]   c_gain, c_diff;
    logic             underflow, overflow;

    always_comb begin
        c_cur     = c_mem[idx];
        p_cur     = p_mem[idx];
        p_dec     = p_cur >> LOG2_STEPS_PER_SECOND;
        c_gain    = {1'b0, c_cur} + (ACC_W+1)'(src_q);
        underflow = (c_gain < {1'b0, p_dec});
        c_diff    = c_gain - {1'b0, p_dec};
        overflow  = !underflow && c_diff[ACC_W];
        if (underflow)     c_new = '0;
        else if (overflow) c_new = '1;
        else               c_new = c_diff[ACC_W-1:0];
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            flux_q                 <= '0;
            idx                    <= '0;
            src_q                  <= '0;
            p_new_q                <= '0;
            acc                    <= '0;
            bus.done               <= 1'b0;
            bus.precursor_neutrons <= '0;
            bus.sat                <= 1'b0;
            bus.overrun            <= 1'b0;
        end else begin
            bus.done <= do_sum;
            if (accept) begin
                flux_q <= bus.neutron_flux;
                idx    <= '0;
                acc    <= '0;
            end
            // Full-width products; truncation happens only at the Q0 shift
            if (do_mul) begin
                src_q   <= FLUX_W'((SRC_W'(flux_q) * SRC_W'(beta_mem[idx])) >> COEF_W);
                p_new_q <= ACC_W'((PL_W'(c_cur) * PL_W'(lambda_mem[idx])) >> COEF_W);
            end
            if (do_upd) begin
                acc <= acc + SUM_W'(p_new_q);
                if (!last_group) idx <= idx + 1'b1;
                if (underflow || overflow) bus.sat <= 1'b1;
            end
            if (do_sum) bus.precursor_neutrons <= acc;
            if (bus.busy && (bus.new_timestep || bus.cfg_we)) bus.overrun <= 1'b1;
        end
    end

    // ---------------- per-group storage ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                c_mem[g]      <= '0;
                p_mem[g]      <= '0;
                beta_mem[g]   <= '0;
                lambda_mem[g] <= '0;
            end
        end else begin
            if (cfg_ok) begin
                case (bus.cfg_sel)
                    2'd0:    beta_mem[bus.cfg_group]   <= bus.cfg_data[COEF_W-1:0];
                    2'd1:    lambda_mem[bus.cfg_group] <= bus.cfg_data[COEF_W-1:0];
                    2'd2:    c_mem[bus.cfg_group]      <= bus.cfg_data;
                    default: ;
                endcase
            end
            if (do_upd) begin
                c_mem[idx] <= c_new;
                p_mem[idx] <= p_new_q;
            end
        end
    end

`ifdef PRECURSOR_GROUP_READ_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bus.rd_amount   <= '0;
            bus.rd_neutrons <= '0;
        end else if ({1'b0, bus.rd_group} < GROUPS) begin
            bus.rd_amount   <= c_mem[bus.rd_group];
            bus.rd_neutrons <= p_mem[bus.rd_group];
        end else begin
            bus.rd_amount   <= '0;
            bus.rd_neutrons <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_precursor_tracker_multi.sv
// tb/tb_precursor_tracker_multi.sv - directed self-checking bench for precursor_tracker_multi
module tb_precursor_tracker_multi;
    localparam int NG = 6;
    localparam int FW = 51;
    localparam int AW = 64;
    localparam int SW = AW + $clog2(NG) + 1;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    precursor_tracker_multi_if #(.NUM_GROUPS(NG), .FLUX_W(FW), .ACC_W(AW)) bus ();

    precursor_tracker_multi #(
        .NUM_GROUPS(NG), .LOG2_STEPS_PER_SECOND(2), .FLUX_W(FW), .ACC_W(AW), .COEF_W(24)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic cfg_write(input int g, input int sel, input logic [63:0] data);
        @(negedge clk_in);
        bus.cfg_we    = 1'b1;
        bus.cfg_group = 3'(g);
        bus.cfg_sel   = 2'(sel);
        bus.cfg_data  = data;
        @(negedge clk_in);
        bus.cfg_we    = 1'b0;
    endtask

    // lat counts edges after the accepting edge until done is visible
    task automatic run_step(input logic [FW-1:0] f, output int lat, output int busy_cnt);
        @(negedge clk_in);
        bus.new_timestep = 1'b1;
        bus.neutron_flux = f;
        @(negedge clk_in);
        bus.new_timestep = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk_in);
            lat++;
        end
    endtask

    task automatic setup_single();
        cfg_write(0, 0, 64'd1 << 20);
        cfg_write(0, 1, 64'd1 << 23);
        cfg_write(0, 2, 64'd1024);
    endtask

    task automatic test_reset();
        bus.new_timestep = 1'b0;
        bus.neutron_flux = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_group = '0;
        bus.cfg_sel = '0;
        bus.cfg_data = '0;
`ifdef PRECURSOR_GROUP_READ_EN
        bus.rd_group = '0;
`endif
        do_reset();
        checks++;
        if ({bus.busy, bus.done, bus.sat, bus.overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.sat, bus.overrun});
        end
        checks++;
        if (bus.precursor_neutrons !== SW'(0)) begin
            errors++;
            $display("FAIL reset_pn: got %0d want 0", bus.precursor_neutrons);
        end
    endtask

    task automatic test_single_group();
        int lat, bc;
        setup_single();
        run_step(51'd4096, lat, bc);
        checks++;
        if (lat !== 13) begin errors++; $display("FAIL latency: got %0d want 13", lat); end
        checks++;
        if (bc !== 13) begin errors++; $display("FAIL busy_cycles: got %0d want 13", bc); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", bus.busy); end
        checks++;
        if (bus.precursor_neutrons !== SW'(512)) begin
            errors++; $display("FAIL step1_pn: got %0d want 512", bus.precursor_neutrons);
        end
        checks++;
        if (dut.c_mem[0] !== 64'd1280) begin
            errors++; $display("FAIL step1_c0: got %0d want 1280", dut.c_mem[0]);
        end
        @(negedge clk_in);
        checks++;
        if (bus.done !== 1'b0 || bus.precursor_neutrons !== SW'(512)) begin
            errors++; $display("FAIL done_pulse_hold: done %b pn %0d want 0/512", bus.done, bus.precursor_neutrons);
        end
        run_step(51'd4096, lat, bc);
        checks++;
        if (bus.precursor_neutrons !== SW'(640)) begin
            errors++; $display("FAIL step2_pn: got %0d want 640", bus.precursor_neutrons);
        end
        checks++;
        if (dut.c_mem[0] !== 64'd1408) begin
            errors++; $display("FAIL step2_c0: got %0d want 1408", dut.c_mem[0]);
        end
        checks++;
        if (bus.sat !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL clean_flags: sat %b overrun %b want 0/0", bus.sat, bus.overrun);
        end
        cfg_write(7, 2, 64'd99);
        cfg_write(0, 3, 64'd99);
        checks++;
        if (dut.c_mem[0] !== 64'd1408 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL discard_write: c0 %0d overrun %b want 1408/0", dut.c_mem[0], bus.overrun);
        end
    endtask

    task automatic test_reset_midrun();
        int seen = 0;
        @(negedge clk_in);
        bus.new_timestep = 1'b1;
        bus.neutron_flux = 51'd4096;
        @(negedge clk_in);
        bus.new_timestep = 1'b0;
        repeat (4) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.precursor_neutrons !== SW'(0)) begin
            errors++; $display("FAIL async_reset: busy %b done %b pn %0d want 0/0/0", bus.busy, bus.done, bus.precursor_neutrons);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0 || dut.c_mem[0] !== 64'd0) begin
            errors++; $display("FAIL post_reset_quiet: activity %0d c0 %0d want 0/0", seen, dut.c_mem[0]);
        end
    endtask

    task automatic test_multi_group();
        int lat, bc;
        do_reset();
        cfg_write(0, 2, 64'd1 << 20);
        cfg_write(5, 2, 64'd1 << 20);
        cfg_write(0, 1, 64'd1 << 23);
        cfg_write(5, 1, 64'd1 << 23);
        run_step(51'd0, lat, bc);
        checks++;
        if (bus.precursor_neutrons !== (SW'(1) << 20)) begin
            errors++; $display("FAIL multi_sum: got %0d want %0d", bus.precursor_neutrons, 1 << 20);
        end
    endtask

    task automatic test_overrun();
        int lat = 0;
        int dones = 0;
        do_reset();
        setup_single();
        @(negedge clk_in);
        bus.new_timestep = 1'b1;
        bus.neutron_flux = 51'd4096;
        @(negedge clk_in);
        bus.new_timestep = 1'b0;
        repeat (2) @(negedge clk_in);
        bus.new_timestep = 1'b1;
        bus.cfg_we = 1'b1;
        bus.cfg_group = 3'd0;
        bus.cfg_sel = 2'd2;
        bus.cfg_data = 64'd0;
        @(negedge clk_in);
        bus.new_timestep = 1'b0;
        bus.cfg_we = 1'b0;
        lat = 3;
        while (!bus.done && lat < 100) begin @(negedge clk_in); lat++; end
        for (int i = 0; i < 30; i++) begin
            if (bus.done) dones++;
            @(negedge clk_in);
        end
        checks++;
        if (lat !== 13 || dones !== 1) begin
            errors++; $display("FAIL overrun_timing: lat %0d dones %0d want 13/1", lat, dones);
        end
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", bus.overrun); end
        checks++;
        if (bus.precursor_neutrons !== SW'(512) || dut.c_mem[0] !== 64'd1280) begin
            errors++; $display("FAIL overrun_result: pn %0d c0 %0d want 512/1280", bus.precursor_neutrons, dut.c_mem[0]);
        end
    endtask

    task automatic test_saturation();
        int lat, bc;
        do_reset();
        cfg_write(0, 2, 64'd1 << 21);
        cfg_write(0, 1, 64'd1 << 23);
        run_step(51'd0, lat, bc);
        checks++;
        if (bus.precursor_neutrons !== (SW'(1) << 20) || bus.sat !== 1'b0) begin
            errors++; $display("FAIL preload: pn %0d sat %b want %0d/0", bus.precursor_neutrons, bus.sat, 1 << 20);
        end
        cfg_write(0, 2, 64'd0);
        run_step(51'd0, lat, bc);
        checks++;
        if (dut.c_mem[0] !== 64'd0 || bus.sat !== 1'b1) begin
            errors++; $display("FAIL underflow: c0 %0d sat %b want 0/1", dut.c_mem[0], bus.sat);
        end
        do_reset();
        cfg_write(0, 2, 64'hFFFF_FFFF_FFFF_FFF0);
        cfg_write(0, 0, 64'd1 << 23);
        run_step(51'd1 << 40, lat, bc);
        checks++;
        if (dut.c_mem[0] !== 64'hFFFF_FFFF_FFFF_FFFF || bus.sat !== 1'b1) begin
            errors++; $display("FAIL overflow: c0 %h sat %b want ffffffffffffffff/1", dut.c_mem[0], bus.sat);
        end
    endtask

    task automatic test_same_cycle();
        int lat = 0;
        do_reset();
        cfg_write(0, 2, 64'd1000);
        @(negedge clk_in);
        bus.cfg_we = 1'b1;
        bus.cfg_group = 3'd0;
        bus.cfg_sel = 2'd0;
        bus.cfg_data = 64'd1 << 20;
        bus.new_timestep = 1'b1;
        bus.neutron_flux = 51'd4096;
        @(negedge clk_in);
        bus.cfg_we = 1'b0;
        bus.new_timestep = 1'b0;
        while (!bus.done && lat < 100) begin @(negedge clk_in); lat++; end
        checks++;
        if (dut.c_mem[0] !== 64'd1256 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL same_cycle: c0 %0d overrun %b want 1256/0", dut.c_mem[0], bus.overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_reset_midrun();
        test_multi_group();
        test_overrun();
        test_saturation();
        test_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/precursor_tracker_multi.md
Name: precursor_tracker_multi

Overview:
- Parametrised successor to the single-group precursor tracker.
- Tracks NUM_GROUPS delayed-neutron precursor groups with runtime-loadable beta/lambda coefficients and loadable initial amounts.
- Shares one time-multiplexed multiply datapath across all groups, so cost stays near-constant as the group count grows.
- Sits beside the core flux integrator: consumes neutron flux each timestep and returns the summed delayed-neutron source.

Parameters:
NUM_GROUPS, 6, number of precursor groups (1..16)
LOG2_STEPS_PER_SECOND, 14, timestep = 2^-LOG2 s; decay term scaled by this
FLUX_W, 51, neutron_flux width
ACC_W, 64, per-group amount/neutron register width
COEF_W, 24, unsigned Q0.COEF_W coefficient width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset
new_timestep  in  1  single-cycle start pulse
neutron_flux  in  FLUX_W  flux; sampled on the accepted new_timestep cycle
cfg_we  in  1  configuration write strobe
cfg_group  in  $clog2(NUM_GROUPS)  target group
cfg_sel  in  2  0=beta, 1=lambda, 2=amount C, 3=reserved
cfg_data  in  ACC_W  write data; beta/lambda use the low COEF_W bits
busy  out  1  high while a timestep is processed
done  out  1  one-cycle pulse when precursor_neutrons is updated
precursor_neutrons  out  ACC_W+$clog2(NUM_GROUPS)+1  sum of group neutron terms
sat  out  1  sticky: some C saturated since reset
overrun  out  1  sticky: new_timestep arrived while busy

Behaviour:
- Reset (rst_in low, async): all C, P, beta, lambda = 0; FSM = IDLE; busy, done, sat, overrun, precursor_neutrons = 0.
- Per group g, using old values:
  - P_new = (C_old*lambda_g) >> COEF_W
  - C_new = C_old + ((flux*beta_g) >> COEF_W) - (P_old >> LOG2_STEPS_PER_SECOND)
- Full-precision products; truncation only at the shifts.
- C saturates: clamps at 0 on underflow and at 2^ACC_W-1 on overflow; either case sets sat.
- FSM IDLE -> MUL -> UPD -> (MUL for next group | SUM) -> IDLE.
  - IDLE: new_timestep latches flux; busy rises next cycle; group index = 0.
  - MUL: register both products for the current group.
  - UPD: write C_new/P_new; accumulate P_new into the running sum; advance the index.
  - SUM: load precursor_neutrons from the accumulator; pulse done; drop busy.
- Latency: done asserts 2*NUM_GROUPS+1 cycles after the accepted new_timestep edge. busy is high for exactly those cycles.
- new_timestep while busy: ignored, overrun set, computation unaffected. new_timestep on the SUM cycle is also ignored; the next one is accepted in IDLE.
- cfg writes: applied next edge only when not busy. While busy they are ignored and set overrun.
- cfg_group >= NUM_GROUPS or cfg_sel=3: write discarded, no flag.
- cfg write and new_timestep in the same IDLE cycle: cfg write takes effect first; the timestep uses the new value.
- precursor_neutrons holds its value between done pulses.
- Reset mid-computation: everything clears immediately; no done pulse.

Optional Feature:
- Macro: PRECURSOR_GROUP_READ_EN.
- Defined:
  - Adds inputs rd_group [$clog2(NUM_GROUPS)].
  - Adds outputs rd_amount [ACC_W] and rd_neutrons [ACC_W], giving C and P of rd_group registered one cycle later.
  - Read allowed anytime; during busy it returns the pre- or post-update value depending on whether that group has passed UPD.
  - Out-of-range rd_group reads 0.
- Undefined: ports absent; no extra logic.

Test Plan:
- Reset: drive rst_in low mid-run -> all outputs 0 asynchronously, no done, busy 0.
- Single group (LOG2=2):
  - Setup: beta0=2^20, lambda0=2^23, C0=1024, others 0; flux=4096, one pulse.
  - Step 1: done at cycle +13; precursor_neutrons=512; C0=1280.
  - Step 2, same flux: precursor_neutrons=640; C0=1408.
- Multi-group sum: C0=C5=2^20, lambda0=lambda5=2^23, flux=0 -> precursor_neutrons=2^20 after one step.
- Overrun: second new_timestep 3 cycles after first -> ignored, overrun=1, result identical to the single-pulse run; cfg_we during busy -> value unchanged.
- Saturation:
  - Underflow: C0=0, P0=2^20 preloaded by a prior step, flux=0 -> C0 clamps to 0, sat=1.
  - Overflow: C0=2^64-16, beta0=2^23, flux=2^40 -> C0=2^64-1, sat=1.
- Same-cycle cfg write and new_timestep: write beta0=2^20 with flux=4096 -> C0 increases by 256 in that step.
